// File: rtl/act_out_pack_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : act_out_pack_pkg
//  Purpose  : Shared constants, result type and round/saturate helper for
//             act_out_pack. Rounding is half-up when ACT_OUT_PACK_ROUND_EN
//             is defined, otherwise the shift truncates toward -inf.
//  Revision : 1.0  initial release
// ============================================================================
package act_out_pack_pkg;

    localparam int C_ACT_CAL_WIDTH   = 16;
    localparam int C_EXT_INT_WIDTH   = 4;
    localparam int C_EXT_FRAC_WIDTH  = 4;
    localparam int C_PACK_N          = 4;
    localparam int C_W               = C_EXT_INT_WIDTH + C_ACT_CAL_WIDTH + C_EXT_FRAC_WIDTH;
    localparam int C_LANE_BYTES      = C_ACT_CAL_WIDTH / 8;
    localparam int C_KEEP_WIDTH      = C_LANE_BYTES * C_PACK_N;
    localparam int C_SAT_CNT_WIDTH   = 16;
    localparam int C_MAX_CAL_WIDTH   = 16;

`ifdef ACT_OUT_PACK_ROUND_EN
    localparam bit C_ROUND_EN = 1'b1;
`else
    localparam bit C_ROUND_EN = 1'b0;
`endif

    typedef struct packed {
        logic                       sat;
        logic [C_MAX_CAL_WIDTH-1:0] val;
    } rs_result_t;

    // 64-bit working width absorbs the rounding carry, so the clamp sees it.
    function automatic rs_result_t round_sat(input logic signed [63:0] x,
                                             input int                 frac_w,
                                             input int                 cal_w,
                                             input bit                 round_en);
        logic signed [63:0] t;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        rs_result_t         r;
        t = x;
        if (round_en && frac_w > 0)
            t = t + (64'sd1 <<< (frac_w - 1));
        t  = t >>> frac_w;
        hi = (64'sd1 <<< (cal_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (cal_w - 1));
        r.sat = 1'b0;
        r.val = t[C_MAX_CAL_WIDTH-1:0];
        if (t > hi) begin
            r.sat = 1'b1;
            r.val = hi[C_MAX_CAL_WIDTH-1:0];
        end else if (t < lo) begin
            r.sat = 1'b1;
            r.val = lo[C_MAX_CAL_WIDTH-1:0];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/act_out_pack_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : act_pack_fifo
//  Purpose  : Synchronous show-ahead word FIFO; head entry reads as zero
//             while empty.
//  Revision : 1.0  initial release
// ============================================================================
module act_pack_fifo #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_data,
    input  logic [KEEP_W-1:0]        i_keep,
    input  logic                     i_last,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_data,
    output logic [KEEP_W-1:0]        o_keep,
    output logic                     o_last,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_ent_w = DATA_W + KEEP_W + 1;
    localparam logic [c_ptr_w:0] c_full = (c_ptr_w + 1)'(DEPTH);

    logic [c_ent_w-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_wr_en;
    logic               w_rd_en;
    logic [c_ent_w-1:0] w_head;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_full);
    assign w_rd_en = i_pop && !o_empty;
    assign w_wr_en = i_push && (!o_full || w_rd_en);
    assign w_head  = o_empty ? '0 : r_mem[r_rd_ptr];
    assign {o_last, o_keep, o_data} = w_head;
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_wr_ptr] <= {i_last, i_keep, i_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en)
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_rd_en)
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            if (w_wr_en && !w_rd_en)
                r_count <= r_count + (c_ptr_w + 1)'(1);
            else if (!w_wr_en && w_rd_en)
                r_count <= r_count - (c_ptr_w + 1)'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/act_out_pack.sv
`default_nettype none
// ============================================================================
//  Module   : act_out_pack
//  Purpose  : Round/saturate activation results, pack PACK_N per word, buffer
//             and stream on AXI-Stream. Macro: ACT_OUT_PACK_ROUND_EN.
//  Revision : 1.0  initial release
// ============================================================================
module act_out_pack
    import act_out_pack_pkg::*;
#(
    parameter int  ACT_CAL_WIDTH         = C_ACT_CAL_WIDTH,
    parameter int  ACT_IN_QUAZ_ACC       = 10,
    parameter int  ACT_IN_EXT_INT_WIDTH  = C_EXT_INT_WIDTH,
    parameter int  ACT_IN_EXT_FRAC_WIDTH = C_EXT_FRAC_WIDTH,
    parameter int  PACK_N                = C_PACK_N,
    parameter int  FIFO_DEPTH            = 16,
    parameter int  ALMOST_FULL_MARGIN    = 4,
    parameter real SIMULATION_DELAY      = 1.0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [ACT_CAL_WIDTH*2-1:0]        act_in,
    input  logic                              act_in_vld,
    input  logic                              act_in_last,
    output logic                              act_in_almost_full,
    output logic [ACT_CAL_WIDTH*PACK_N-1:0]   m_axis_data,
    output logic [ACT_CAL_WIDTH*PACK_N/8-1:0] m_axis_keep,
    output logic                              m_axis_last,
    output logic                              m_axis_valid,
    input  logic                              m_axis_ready,
    output logic [C_SAT_CNT_WIDTH-1:0]        sat_cnt,
    input  logic                              sat_cnt_clr,
    output logic                              ovf_err
);

    localparam int c_w          = ACT_IN_EXT_INT_WIDTH + ACT_CAL_WIDTH + ACT_IN_EXT_FRAC_WIDTH;
    localparam int c_lane_bytes = ACT_CAL_WIDTH / 8;
    localparam int c_keep_w     = c_lane_bytes * PACK_N;
    localparam int c_data_w     = ACT_CAL_WIDTH * PACK_N;
    localparam int c_lane_w     = (PACK_N > 1) ? $clog2(PACK_N) : 1;
    localparam int c_cnt_w      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_lane_w-1:0] c_lane_max  = c_lane_w'(PACK_N - 1);
    localparam logic [c_cnt_w-1:0]  c_af_thresh = c_cnt_w'(FIFO_DEPTH - ALMOST_FULL_MARGIN);

    // Quantization precision and sim delay only describe the upstream contract.
    if (ACT_IN_QUAZ_ACC >= 0 && SIMULATION_DELAY >= 0.0) begin : g_cfg_info
    end

    if (c_w < 2 * ACT_CAL_WIDTH) begin : g_unused_hi
        logic w_unused_hi;
        assign w_unused_hi = ^act_in[2*ACT_CAL_WIDTH-1:c_w];
    end

    logic signed [63:0]           w_ext;
    rs_result_t                   w_rs;
    logic                         r_s1_vld;
    logic                         r_s1_last;
    logic [ACT_CAL_WIDTH-1:0]     r_s1_val;
    logic [C_SAT_CNT_WIDTH-1:0]   r_sat_cnt;
    logic [c_lane_w-1:0]          r_lane;
    logic [c_data_w-1:0]          r_acc;
    logic [c_data_w-1:0]          w_merged;
    logic [c_keep_w-1:0]          w_keep;
    logic                         w_done;
    logic                         w_pop;
    logic                         w_full;
    logic                         w_empty;
    logic [c_cnt_w-1:0]           w_count;
    logic                         r_af;
    logic                         r_ovf;

    assign w_ext = {{(64 - c_w){act_in[c_w-1]}}, act_in[c_w-1:0]};
    assign w_rs  = round_sat(w_ext, ACT_IN_EXT_FRAC_WIDTH, ACT_CAL_WIDTH, C_ROUND_EN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_val  <= '0;
            r_sat_cnt <= '0;
        end else begin
            r_s1_vld  <= act_in_vld;
            r_s1_last <= act_in_vld && act_in_last;
            if (act_in_vld)
                r_s1_val <= w_rs.val[ACT_CAL_WIDTH-1:0];
            // Clear wins over a coincident increment.
            if (sat_cnt_clr)
                r_sat_cnt <= '0;
            else if (act_in_vld && w_rs.sat && r_sat_cnt != '1)
                r_sat_cnt <= r_sat_cnt + C_SAT_CNT_WIDTH'(1);
        end
    end

    always_comb begin
        w_merged = r_acc;
        w_merged[r_lane*ACT_CAL_WIDTH +: ACT_CAL_WIDTH] = r_s1_val;
        w_keep = '0;
        for (int l = 0; l < PACK_N; l++) begin
            if (l <= int'(r_lane))
                w_keep[l*c_lane_bytes +: c_lane_bytes] = '1;
        end
    end

    assign w_done = r_s1_vld && (r_lane == c_lane_max || r_s1_last);
    assign w_pop  = m_axis_valid && m_axis_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane <= '0;
            r_acc  <= '0;
            r_af   <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            // Completed words restart from a zeroed accumulator, dropped or not.
            if (w_done) begin
                r_lane <= '0;
                r_acc  <= '0;
            end else if (r_s1_vld) begin
                r_lane <= r_lane + c_lane_w'(1);
                r_acc  <= w_merged;
            end
            r_af <= (w_count >= c_af_thresh);
            if (w_done && w_full && !w_pop)
                r_ovf <= 1'b1;
        end
    end

    act_pack_fifo #(
        .DATA_W (c_data_w),
        .KEEP_W (c_keep_w),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_done),
        .i_data  (w_merged),
        .i_keep  (w_keep),
        .i_last  (r_s1_last),
        .i_pop   (w_pop),
        .o_data  (m_axis_data),
        .o_keep  (m_axis_keep),
        .o_last  (m_axis_last),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign m_axis_valid       = !w_empty;
    assign act_in_almost_full = r_af;
    assign sat_cnt            = r_sat_cnt;
    assign ovf_err            = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_act_out_pack.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_act_out_pack
//  Purpose  : Directed stimulus with a queue-based reference model for
//             act_out_pack (default parameters). Honours ACT_OUT_PACK_ROUND_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_act_out_pack;

    localparam int N     = 4;
    localparam int DEPTH = 16;
`ifdef ACT_OUT_PACK_ROUND_EN
    localparam bit          ROUND    = 1'b1;
    localparam logic [63:0] EXP_RND  = 64'h0001_0000_0002_0012;
    localparam int          EXP_SAT3 = 3;
`else
    localparam bit          ROUND    = 1'b0;
    localparam logic [63:0] EXP_RND  = 64'h0001_FFFF_0001_0012;
    localparam int          EXP_SAT3 = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] act_in = '0;
    logic        act_in_vld = 1'b0;
    logic        act_in_last = 1'b0;
    logic        act_in_almost_full;
    logic [63:0] m_axis_data;
    logic [7:0]  m_axis_keep;
    logic        m_axis_last;
    logic        m_axis_valid;
    logic        m_axis_ready = 1'b0;
    logic [15:0] sat_cnt;
    logic        sat_cnt_clr = 1'b0;
    logic        ovf_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    act_out_pack dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .act_in             (act_in),
        .act_in_vld         (act_in_vld),
        .act_in_last        (act_in_last),
        .act_in_almost_full (act_in_almost_full),
        .m_axis_data        (m_axis_data),
        .m_axis_keep        (m_axis_keep),
        .m_axis_last        (m_axis_last),
        .m_axis_valid       (m_axis_valid),
        .m_axis_ready       (m_axis_ready),
        .sat_cnt            (sat_cnt),
        .sat_cnt_clr        (sat_cnt_clr),
        .ovf_err            (ovf_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } word_t;

    word_t       mq[$];
    logic [15:0] lanes[$];
    word_t       pend;
    bit          pend_v = 0;
    int          m_sat = 0;
    bit          m_ovf = 0;
    bit          m_af = 0;

    // 24-bit two's complement input, 4 fraction bits, clamp to int16.
    function automatic void ref_round(input logic [31:0] x, output logic [15:0] v, output bit s);
        longint a;
        a = longint'($signed(x[23:0]));
        if (ROUND) a = a + 8;
        if (a >= 0) a = a / 16;
        else        a = -((-a + 15) / 16);
        s = 1'b0;
        if (a > 32767)       begin a = 32767;  s = 1'b1; end
        else if (a < -32768) begin a = -32768; s = 1'b1; end
        v = 16'(a);
    endfunction

    initial forever begin
        logic [15:0] v;
        bit          s;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            lanes.delete();
            pend_v = 0;
            m_sat  = 0;
            m_ovf  = 0;
            m_af   = 0;
        end else begin
            m_af = (mq.size() >= DEPTH - 4);
            if (mq.size() > 0 && m_axis_ready) mq.delete(0);
            if (pend_v) begin
                if (mq.size() < DEPTH) mq.push_back(pend);
                else                   m_ovf = 1;
                pend_v = 0;
            end
            if (act_in_vld) begin
                ref_round(act_in, v, s);
                if (s && m_sat < 65535) m_sat++;
                lanes.push_back(v);
                if (lanes.size() == N || act_in_last) begin
                    pend.data = '0;
                    pend.keep = '0;
                    pend.last = act_in_last;
                    for (int i = 0; i < lanes.size(); i++) begin
                        pend.data[16*i +: 16] = lanes[i];
                        pend.keep[2*i +: 2]   = 2'b11;
                    end
                    pend_v = 1;
                    lanes.delete();
                end
            end
            if (sat_cnt_clr) m_sat = 0;
        end
    end

    // ---------------- per-cycle comparison ----------------
    initial forever begin
        word_t e;
        @(posedge clk);
        #1;
        e.data = '0; e.keep = '0; e.last = 1'b0;
        if (mq.size() > 0) e = mq[0];
        chk("valid",   m_axis_valid,       mq.size() > 0);
        chk("data",    m_axis_data,        e.data);
        chk("keep",    m_axis_keep,        e.keep);
        chk("last",    m_axis_last,        e.last);
        chk("afull",   act_in_almost_full, m_af);
        chk("sat_cnt", sat_cnt,            m_sat);
        chk("ovf_err", ovf_err,            m_ovf);
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [31:0] v, input bit last);
        act_in      = v;
        act_in_vld  = 1'b1;
        act_in_last = last;
        @(negedge clk);
        act_in_vld  = 1'b0;
        act_in_last = 1'b0;
    endtask

    task automatic pop_one();
        m_axis_ready = 1'b1;
        @(negedge clk);
        m_axis_ready = 1'b0;
    endtask

    task automatic drain(input int limit, output int nw);
        nw = 0;
        m_axis_ready = 1'b1;
        for (int k = 0; k < limit && m_axis_valid; k++) begin
            nw++;
            @(negedge clk);
        end
        m_axis_ready = 1'b0;
        chk("drain_done", m_axis_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        int after;
        int nw;

        repeat (3) @(negedge clk);
        chk("rst_valid", m_axis_valid, 1'b0);
        chk("rst_data",  m_axis_data,  64'h0);
        chk("rst_keep",  m_axis_keep,  8'h0);
        chk("rst_afull", act_in_almost_full, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // rounding and latency
        send(32'h000123, 0); send(32'h000018, 0); send(32'hFFFFF8, 0); send(32'h000017, 0);
        chk("lat_early", m_axis_valid, 1'b0);
        @(negedge clk);
        chk("lat_valid", m_axis_valid, 1'b1);
        chk("rnd_data",  m_axis_data,  EXP_RND);
        chk("rnd_keep",  m_axis_keep,  8'hFF);
        pop_one();

        // saturation and counter clear
        send(32'h07FFFF, 0); send(32'h800000, 0); send(32'h07FFF0, 0); send(32'h080000, 0);
        @(negedge clk);
        chk("sat_data", m_axis_data, 64'h7FFF_7FFF_8000_7FFF);
        chk("sat_cnt3", sat_cnt, EXP_SAT3);
        sat_cnt_clr = 1'b1;
        @(negedge clk);
        sat_cnt_clr = 1'b0;
        chk("sat_clr", sat_cnt, 16'h0);
        pop_one();
        sat_cnt_clr = 1'b1;
        send(32'h800000, 1);
        sat_cnt_clr = 1'b0;
        chk("sat_clr_inc", sat_cnt, 16'h0);
        @(negedge clk);
        chk("one_lane_keep", m_axis_keep, 8'h03);
        pop_one();

        // partial word
        send(32'h000100, 0); send(32'h000200, 1);
        @(negedge clk);
        chk("part_data", m_axis_data, 64'h0000_0000_0020_0010);
        chk("part_keep", m_axis_keep, 8'h0F);
        chk("part_last", m_axis_last, 1'b1);
        pop_one();
        send(32'h10, 0); send(32'h20, 0); send(32'h30, 0); send(32'h40, 0);
        @(negedge clk);
        chk("next_data", m_axis_data, 64'h0004_0003_0002_0001);
        chk("next_keep", m_axis_keep, 8'hFF);
        pop_one();

        // backpressure: stop two results after almost_full is seen
        i = 0;
        after = -1;
        while (i < 64 && after != 0) begin
            send(32'(i << 4), 0);
            i++;
            if (after > 0) after--;
            else if (after < 0 && act_in_almost_full) after = 2;
        end
        chk("bp_af_seen", after, 0);
        chk("bp_af",      act_in_almost_full, 1'b1);
        chk("bp_no_ovf",  ovf_err, 1'b0);
        send(32'(i << 4), 1);
        @(negedge clk);
        drain(40, nw);
        chk("bp_words", nw, (i + 1 + 3) / 4);

        // overflow: ignore almost_full
        for (int j = 0; j < 80; j++) send(32'(j << 4), 0);
        @(negedge clk);
        chk("ovf_set",  ovf_err, 1'b1);
        chk("ovf_head", m_axis_data, 64'h0003_0002_0001_0000);
        drain(40, nw);
        chk("ovf_words", nw, DEPTH);

        // reset mid-word with a buffered word
        send(32'h10, 0); send(32'h800000, 0); send(32'h30, 0); send(32'h40, 0);
        send(32'h10, 0); send(32'h20, 0); send(32'h30, 0);
        chk("pre_rst_sat", sat_cnt, 16'h1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", m_axis_valid, 1'b0);
        chk("mid_rst_ovf",   ovf_err, 1'b0);
        chk("mid_rst_sat",   sat_cnt, 16'h0);
        chk("mid_rst_data",  m_axis_data, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        send(32'h50, 0); send(32'h60, 0); send(32'h70, 0); send(32'h80, 0);
        @(negedge clk);
        chk("post_rst_data", m_axis_data, 64'h0008_0007_0006_0005);
        chk("post_rst_keep", m_axis_keep, 8'hFF);
        pop_one();
        repeat (3) @(negedge clk);
        chk("post_rst_one", m_axis_valid, 1'b0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
